date_set_controller: RTL and testbench
======================================

Name: date_set_controller

Overview:
- Sequencing controller for the BCD calendar datapath: holds the YY/MM/DD date and advances it one day per 1 Hz tick in RUN mode.
- Provides a button-driven edit FSM to set year, month and day.
- Outputs six BCD digits plus edit/blank indicators for the BCD-to-7-segment decoders and display controller.
- No leap years: February always has 28 days.

Parameters:
- INIT_YEAR, 0, reset year (binary, 0-99).
- INIT_MONTH, 1, reset month (binary, 1-12).
- INIT_DAY, 1, reset day (binary, 1 to month length of INIT_MONTH).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- tick  input  1  one-clk-wide 1 Hz enable pulse from the frequency divider
- btn_mode  input  1  debounced one-pulse mode button
- btn_inc  input  1  debounced one-pulse increment button
- year1, year0  output  4 each  BCD year tens/units
- month1, month0  output  4 each  BCD month tens/units
- day1, day0  output  4 each  BCD day tens/units
- edit_field  output  2  0=none (RUN), 1=year, 2=month, 3=day
- blank  output  1  1 = display should blank the digits of edit_field

Behaviour:
- Reset (async, rst=1):
  - date = INIT_YEAR/INIT_MONTH/INIT_DAY; state RUN; edit_field=0; blank=0.
  - Reset mid-edit discards the edit and returns to RUN immediately.
- All outputs registered. Effects appear on the clk edge that samples the input (1-cycle latency). BCD digits change together, never partially.
- Month length: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; 28 for 2.
- States and transitions (btn_mode pulse):
  - RUN -> SET_Y -> SET_M -> SET_D -> RUN.
  - edit_field = 0/1/2/3 respectively.
- RUN, on tick:
  - Day below month length: day+1.
  - Day at month length: day=01 and month+1.
  - Month 12 rolls to 01 with year+1.
  - Year 99 rolls to 00.
  - Example: 99/12/31 -> 00/01/01.
  - btn_inc is ignored in RUN.
- SET_Y / SET_M / SET_D, on btn_inc, the selected field increments with wrap:
  - year 99->00
  - month 12->01
  - day at month length ->01
  - tick does not advance the date in any SET state.
- Day clamp:
  - On any month change in SET_M, if day > new month length, day = new month length in the same cycle.
  - Example: 01/31 inc -> 02/28.
- blank:
  - In SET states, toggles on every tick.
  - Forced to 0 on every state transition and in RUN.
- Simultaneous events:
  - btn_mode + btn_inc in same cycle: mode transition only; inc dropped.
  - btn_mode + tick in RUN: transition to SET_Y; the date is not advanced.
  - btn_mode + tick in SET_D: return to RUN; that tick is not counted.
- Internal counters may be binary with combinational binary-to-BCD at the outputs, or native BCD. Output values must be identical either way.
- Illegal state encodings recover to RUN on the next clk.

Test Plan:
- Reset with defaults -> outputs 0/0/0/1/0/1 (00/01/01), edit_field=0, blank=0; 31 ticks -> 00/02/01; 28 more ticks -> 00/03/01.
- Preload 99/12/31 via edit sequence, return to RUN, 1 tick -> 00/01/01 with all six digits updating on the same clk edge.
- btn_mode x1, btn_inc x3 -> year 03, edit_field=1; 5 ticks during SET_Y -> date unchanged, blank toggles 5 times; btn_mode -> edit_field=2, blank=0.
- Set 00/01/31, enter SET_M, btn_inc -> 00/02/28; btn_inc x2 -> 00/04/28; in SET_D, btn_inc x3 -> 00/04/01 (28->29->30->01).
- btn_mode and btn_inc asserted together in SET_M -> edit_field becomes 3, month unchanged; btn_mode and tick together in RUN -> edit_field=1, date unchanged.
- Assert rst while in SET_D with edited date -> immediately 00/01/01, edit_field=0, blank=0; release rst, next tick -> 00/01/02.

Source files
------------

// File: rtl/date_set_controller.sv
// YY/MM/DD calendar controller: advances one day per tick in RUN and lets the user edit
// year, month and day through a mode/increment button FSM.
module date_set_controller #(
  parameter int unsigned INIT_YEAR  = 0,
  parameter int unsigned INIT_MONTH = 1,
  parameter int unsigned INIT_DAY   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_tick,
  input  logic       i_btn_mode,
  input  logic       i_btn_inc,
  output logic [3:0] o_year1,
  output logic [3:0] o_year0,
  output logic [3:0] o_month1,
  output logic [3:0] o_month0,
  output logic [3:0] o_day1,
  output logic [3:0] o_day0,
  output logic [1:0] o_edit_field,
  output logic       o_blank
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SET_Y = 2'd1;
  localparam logic [1:0] ST_SET_M = 2'd2;
  localparam logic [1:0] ST_SET_D = 2'd3;

  logic [1:0] r_state;
  logic [6:0] r_year;
  logic [3:0] r_month;
  logic [4:0] r_day;
  logic       r_blank;

  logic [1:0] w_state_nxt;
  logic [6:0] w_year_nxt;
  logic [3:0] w_month_nxt;
  logic [4:0] w_day_nxt;
  logic       w_blank_nxt;
  logic [6:0] w_year_inc;
  logic [3:0] w_month_inc;
  logic [4:0] w_cur_len;
  logic [4:0] w_inc_len;

  function automatic logic [4:0] month_len(input logic [3:0] m);
    case (m)
      4'd2:                      return 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  assign w_year_inc  = (r_year == 7'd99) ? 7'd0 : r_year + 7'd1;
  assign w_month_inc = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
  assign w_cur_len   = month_len(r_month);
  assign w_inc_len   = month_len(w_month_inc);

  always_comb begin
    w_state_nxt = r_state;
    w_year_nxt  = r_year;
    w_month_nxt = r_month;
    w_day_nxt   = r_day;
    w_blank_nxt = r_blank;
    // A mode press wins over both inc and tick in the same cycle.
    if (i_btn_mode) begin
      w_state_nxt = r_state + 2'd1;
      w_blank_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          w_blank_nxt = 1'b0;
          if (i_tick) begin
            if (r_day >= w_cur_len) begin
              w_day_nxt   = 5'd1;
              w_month_nxt = w_month_inc;
              if (r_month == 4'd12) w_year_nxt = w_year_inc;
            end else begin
              w_day_nxt = r_day + 5'd1;
            end
          end
        end
        ST_SET_Y: begin
          if (i_btn_inc) w_year_nxt = w_year_inc;
          if (i_tick) w_blank_nxt = ~r_blank;
        end
        ST_SET_M: begin
          if (i_btn_inc) begin
            w_month_nxt = w_month_inc;
            if (r_day > w_inc_len) w_day_nxt = w_inc_len;
          end
          if (i_tick) w_blank_nxt = ~r_blank;
        end
        ST_SET_D: begin
          if (i_btn_inc) w_day_nxt = (r_day >= w_cur_len) ? 5'd1 : r_day + 5'd1;
          if (i_tick) w_blank_nxt = ~r_blank;
        end
        default: begin
          w_state_nxt = ST_RUN;
          w_blank_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_year  <= 7'(INIT_YEAR);
      r_month <= 4'(INIT_MONTH);
      r_day   <= 5'(INIT_DAY);
      r_blank <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_year  <= w_year_nxt;
      r_month <= w_month_nxt;
      r_day   <= w_day_nxt;
      r_blank <= w_blank_nxt;
    end
  end

  // Digits derive from a single set of registers, so they always change together.
  assign o_year1      = 4'(r_year / 7'd10);
  assign o_year0      = 4'(r_year % 7'd10);
  assign o_month1     = (r_month >= 4'd10) ? 4'd1 : 4'd0;
  assign o_month0     = (r_month >= 4'd10) ? r_month - 4'd10 : r_month;
  assign o_day1       = 4'(r_day / 5'd10);
  assign o_day0       = 4'(r_day % 5'd10);
  assign o_edit_field = r_state;
  assign o_blank      = r_blank;

endmodule

// File: tb/tb_date_set_controller.sv
// Directed bench for date_set_controller: reset, day rollover, edit FSM, clamp and
// simultaneous-event handling.
module tb_date_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] year1, year0, month1, month0, day1, day0;
  logic [1:0] edit_field;
  logic       blank;

  int total = 0;
  int bad   = 0;

  date_set_controller dut (
    .clk         (clk),
    .rst         (rst),
    .i_tick      (tick),
    .i_btn_mode  (btn_mode),
    .i_btn_inc   (btn_inc),
    .o_year1     (year1),
    .o_year0     (year0),
    .o_month1    (month1),
    .o_month0    (month0),
    .o_day1      (day1),
    .o_day0      (day0),
    .o_edit_field(edit_field),
    .o_blank     (blank)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs, then inputs low; returns #1 after the edge.
  task automatic cyc(input logic m, input logic i, input logic t);
    btn_mode = m;
    btn_inc  = i;
    tick     = t;
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    tick     = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic incs(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] date_bcd();
    return {year1, year0, month1, month0, day1, day0};
  endfunction

  initial begin
    // Reset
    @(posedge clk);
    #1;
    check("rst_date", date_bcd(), 24'h000101);
    check("rst_edit", 24'(edit_field), 24'd0);
    check("rst_blank", 24'(blank), 24'd0);
    rst = 1'b0;

    // Month rollovers in RUN
    ticks(31);
    check("run_jan_end", date_bcd(), 24'h000201);
    ticks(28);
    check("run_feb_end", date_bcd(), 24'h000301);
    cyc(1'b0, 1'b1, 1'b0);
    check("run_inc_ignored", date_bcd(), 24'h000301);

    // Preload 99/12/31 and roll the century
    cyc(1'b1, 1'b0, 1'b0);
    incs(99);
    cyc(1'b1, 1'b0, 1'b0);
    incs(9);
    cyc(1'b1, 1'b0, 1'b0);
    incs(30);
    cyc(1'b1, 1'b0, 1'b0);
    check("preload", date_bcd(), 24'h991231);
    check("preload_edit", 24'(edit_field), 24'd0);
    ticks(1);
    check("century_roll", date_bcd(), 24'h000101);

    // Year edit, blink
    cyc(1'b1, 1'b0, 1'b0);
    incs(3);
    check("sety_date", date_bcd(), 24'h030101);
    check("sety_edit", 24'(edit_field), 24'd1);
    for (int k = 0; k < 5; k++) begin
      ticks(1);
      check("sety_blank", 24'(blank), 24'(k % 2 == 0));
    end
    check("sety_frozen", date_bcd(), 24'h030101);
    cyc(1'b1, 1'b0, 1'b0);
    check("setm_edit", 24'(edit_field), 24'd2);
    check("setm_blank", 24'(blank), 24'd0);

    // Day clamp on month change
    rst = 1'b1;
    #1;
    rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    incs(30);
    cyc(1'b1, 1'b0, 1'b0);
    check("set_0131", date_bcd(), 24'h000131);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    incs(1);
    check("clamp_feb", date_bcd(), 24'h000228);
    incs(2);
    check("apr_28", date_bcd(), 24'h000428);
    cyc(1'b1, 1'b0, 1'b0);
    incs(3);
    check("day_wrap", date_bcd(), 24'h000401);

    // Simultaneous events
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    check("setm_again", 24'(edit_field), 24'd2);
    cyc(1'b1, 1'b1, 1'b0);
    check("mode_inc_edit", 24'(edit_field), 24'd3);
    check("mode_inc_date", date_bcd(), 24'h000401);
    cyc(1'b1, 1'b0, 1'b1);
    check("setd_tick_edit", 24'(edit_field), 24'd0);
    check("setd_tick_date", date_bcd(), 24'h000401);
    cyc(1'b1, 1'b0, 1'b1);
    check("run_tick_edit", 24'(edit_field), 24'd1);
    check("run_tick_date", date_bcd(), 24'h000401);

    // Async reset mid-edit
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    incs(1);
    ticks(1);
    check("setd_pre_rst", date_bcd(), 24'h000402);
    check("setd_blank", 24'(blank), 24'd1);
    rst = 1'b1;
    #1;
    check("async_date", date_bcd(), 24'h000101);
    check("async_edit", 24'(edit_field), 24'd0);
    check("async_blank", 24'(blank), 24'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ticks(1);
    check("post_rst_tick", date_bcd(), 24'h000102);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
